// File: rtl/fsm_timer_ctrl_pkg.sv
// Shared types and defaults for the START/RESET/READY timer link initiator.
package fsm_timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        ACK   = 3'd4,
        FIN   = 3'd5,
        ABRT  = 3'd6,
        ERR   = 3'd7
    } ctrl_state_t;

    localparam int N_DEF       = 256;
    localparam int TIMEOUT_DEF = N_DEF + 4;

    // Watchdog must hold TIMEOUT itself so that it can saturate there.
    function automatic int wdog_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fsm_timer_ctrl_wdog.sv
// Saturating WAIT-cycle watchdog; expired flags the last permitted WAIT cycle.
module fsm_wdog
    import fsm_timer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic N_RESET,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = wdog_w(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != W'(TIMEOUT))
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/fsm_timer_ctrl.sv
// Runs the linked N-state timer REQ_REPS times per accepted request, with abort and watchdog.
module fsm_timer_ctrl
    import fsm_timer_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int RW      = 8,
    parameter int TIMEOUT = N + 4
) (
    input  logic          CLK,
    input  logic          N_RESET,
    input  logic          REQ_VALID,
    input  logic [RW-1:0] REQ_REPS,
    output logic          REQ_READY,
    input  logic          ABORT,
    input  logic          TIMER_READY,
    output logic          TIMER_START,
    output logic          TIMER_RESET,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERROR,
    output logic [RW-1:0] REPS_LEFT
);

    // A misconfigured TIMEOUT is raised so a healthy timer can always answer first.
    localparam int WD_LIMIT = (TIMEOUT > N - 1) ? TIMEOUT : N;

    ctrl_state_t state, state_nxt;
    logic        accept;
    logic        wd_expired;

    assign accept = (state == IDLE) && REQ_VALID;

    fsm_wdog #(.TIMEOUT(WD_LIMIT)) u_wdog (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .clr     (state == ARM),
        .en      (state == WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ABORT outranks READY and watchdog expiry in every abortable state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (REQ_VALID) state_nxt = (REQ_REPS == '0) ? FIN : CLEAR;
            CLEAR: state_nxt = ABORT ? ABRT : ARM;
            ARM:   state_nxt = ABORT ? ABRT : WAIT;
            WAIT: begin
                if (ABORT)            state_nxt = ABRT;
                else if (TIMER_READY) state_nxt = ACK;
                else if (wd_expired)  state_nxt = ERR;
            end
            ACK: begin
                if (ABORT)                   state_nxt = ABRT;
                else if (REPS_LEFT > RW'(1)) state_nxt = ARM;
                else                         state_nxt = FIN;
            end
            FIN, ABRT, ERR: state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY   = (state == IDLE);
        BUSY        = (state != IDLE);
        TIMER_START = (state == ARM);
        TIMER_RESET = (state == CLEAR) || (state == ACK) ||
                      (state == ABRT)  || (state == ERR);
        DONE        = (state == FIN);
    end

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            REPS_LEFT <= '0;
            ERROR     <= 1'b0;
        end else begin
            if (accept) begin
                REPS_LEFT <= REQ_REPS;
                ERROR     <= 1'b0;
            end else if (state == ACK) begin
                REPS_LEFT <= REPS_LEFT - 1'b1;
            end else if (state == ABRT) begin
                REPS_LEFT <= '0;
            end else if (state == ERR) begin
                REPS_LEFT <= '0;
                ERROR     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fsm_timer_ctrl.sv
// Directed bench: controller linked to a behavioural 8-state timer, TIMEOUT=12.
module tb_fsm_timer_ctrl;

    localparam int N       = 8;
    localparam int RW      = 8;
    localparam int TIMEOUT = 12;

    logic          CLK = 1'b0;
    logic          N_RESET = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic [RW-1:0] REQ_REPS = '0;
    logic          REQ_READY;
    logic          ABORT = 1'b0;
    logic          TIMER_READY;
    logic          TIMER_START;
    logic          TIMER_RESET;
    logic          BUSY;
    logic          DONE;
    logic          ERROR;
    logic [RW-1:0] REPS_LEFT;

    int checks = 0;
    int passed = 0;

    logic       tie_low = 1'b0;
    logic [3:0] tstate;

    always #5 CLK = ~CLK;

    // Linked timer: RESET forces state 0, START leaves 0, then counts up and holds at N-1.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET)                              tstate <= '0;
        else if (TIMER_RESET)                      tstate <= '0;
        else if (TIMER_START && tstate == 4'd0)    tstate <= 4'd1;
        else if (tstate != 4'd0 && tstate != N-1)  tstate <= tstate + 1'b1;
    end
    assign TIMER_READY = !tie_low && (tstate == 4'(N - 1));

    fsm_timer_ctrl #(.N(N), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .N_RESET(N_RESET), .REQ_VALID(REQ_VALID), .REQ_REPS(REQ_REPS),
        .REQ_READY(REQ_READY), .ABORT(ABORT), .TIMER_READY(TIMER_READY),
        .TIMER_START(TIMER_START), .TIMER_RESET(TIMER_RESET), .BUSY(BUSY),
        .DONE(DONE), .ERROR(ERROR), .REPS_LEFT(REPS_LEFT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic accept(input logic [RW-1:0] reps);
        REQ_VALID = 1'b1;
        REQ_REPS  = reps;
        tick();
        REQ_VALID = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        got = {REQ_READY, BUSY, TIMER_START, TIMER_RESET, DONE, ERROR};
        checks++;
        if (got !== 6'b100000 || REPS_LEFT !== '0)
            $display("FAIL reset_init ctl=%b reps=%0d want ctl=100000 reps=0", got, REPS_LEFT);
        else passed++;
        @(negedge CLK);
        N_RESET = 1'b1;
        accept(8'd1);
        repeat (4) tick();
        checks++;
        if (BUSY !== 1'b1 || TIMER_START !== 1'b0 || TIMER_RESET !== 1'b0)
            $display("FAIL reset_prewait busy=%b st=%b rs=%b want 1 0 0", BUSY, TIMER_START, TIMER_RESET);
        else passed++;
        #2;
        N_RESET = 1'b0;
        #1;
        got = {REQ_READY, BUSY, TIMER_START, TIMER_RESET, DONE, ERROR};
        checks++;
        if (got !== 6'b100000 || REPS_LEFT !== '0)
            $display("FAIL reset_async ctl=%b reps=%0d want ctl=100000 reps=0", got, REPS_LEFT);
        else passed++;
        @(negedge CLK);
        N_RESET = 1'b1;
    endtask

    task automatic test_two_runs();
        logic          exp_start, exp_rst, exp_done;
        logic [RW-1:0] exp_reps;
        accept(8'd2);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            if (k == 3) REQ_REPS = 8'd9;
            exp_start = (k == 1) || (k == 10);
            exp_rst   = (k == 0) || (k == 9) || (k == 18);
            exp_done  = (k == 19);
            exp_reps  = (k <= 9) ? 8'd2 : (k <= 18) ? 8'd1 : 8'd0;
            checks++;
            if (TIMER_START !== exp_start || TIMER_RESET !== exp_rst || DONE !== exp_done ||
                REPS_LEFT !== exp_reps || BUSY !== (k <= 19))
                $display("FAIL two_runs k=%0d st=%b rs=%b dn=%b reps=%0d busy=%b want %b %b %b %0d %b",
                         k, TIMER_START, TIMER_RESET, DONE, REPS_LEFT, BUSY,
                         exp_start, exp_rst, exp_done, exp_reps, (k <= 19));
            else passed++;
        end
    endtask

    task automatic test_zero_reps();
        accept(8'd0);
        checks++;
        if (DONE !== 1'b1 || TIMER_START !== 1'b0 || TIMER_RESET !== 1'b0 || BUSY !== 1'b1)
            $display("FAIL zero_reps_fin dn=%b st=%b rs=%b busy=%b want 1 0 0 1", DONE, TIMER_START, TIMER_RESET, BUSY);
        else passed++;
        tick();
        checks++;
        if (DONE !== 1'b0 || REQ_READY !== 1'b1 || TIMER_START !== 1'b0 || TIMER_RESET !== 1'b0)
            $display("FAIL zero_reps_idle dn=%b rdy=%b st=%b rs=%b want 0 1 0 0", DONE, REQ_READY, TIMER_START, TIMER_RESET);
        else passed++;
    endtask

    task automatic test_abort_vs_ready();
        accept(8'd3);
        repeat (8) tick();
        checks++;
        if (TIMER_READY !== 1'b1 || REPS_LEFT !== 8'd3)
            $display("FAIL abort_setup ready=%b reps=%0d want 1 3", TIMER_READY, REPS_LEFT);
        else passed++;
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        checks++;
        if (TIMER_RESET !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b1 || TIMER_START !== 1'b0)
            $display("FAIL abort_abrt rs=%b dn=%b busy=%b st=%b want 1 0 1 0", TIMER_RESET, DONE, BUSY, TIMER_START);
        else passed++;
        tick();
        checks++;
        if (REQ_READY !== 1'b1 || REPS_LEFT !== 8'd0 || DONE !== 1'b0 || TIMER_RESET !== 1'b0)
            $display("FAIL abort_idle rdy=%b reps=%0d dn=%b rs=%b want 1 0 0 0", REQ_READY, REPS_LEFT, DONE, TIMER_RESET);
        else passed++;
    endtask

    task automatic test_watchdog();
        tie_low = 1'b1;
        accept(8'd1);
        repeat (13) tick();
        checks++;
        if (BUSY !== 1'b1 || TIMER_RESET !== 1'b0)
            $display("FAIL wdog_last_wait busy=%b rs=%b want 1 0", BUSY, TIMER_RESET);
        else passed++;
        tick();
        checks++;
        if (TIMER_RESET !== 1'b1 || BUSY !== 1'b1 || DONE !== 1'b0)
            $display("FAIL wdog_err rs=%b busy=%b dn=%b want 1 1 0", TIMER_RESET, BUSY, DONE);
        else passed++;
        tick();
        checks++;
        if (ERROR !== 1'b1 || REQ_READY !== 1'b1 || REPS_LEFT !== 8'd0 || DONE !== 1'b0)
            $display("FAIL wdog_idle err=%b rdy=%b reps=%0d dn=%b want 1 1 0 0", ERROR, REQ_READY, REPS_LEFT, DONE);
        else passed++;
        repeat (3) tick();
        checks++;
        if (ERROR !== 1'b1)
            $display("FAIL wdog_sticky err=%b want 1", ERROR);
        else passed++;
        tie_low = 1'b0;
        accept(8'd0);
        checks++;
        if (ERROR !== 1'b0 || DONE !== 1'b1)
            $display("FAIL wdog_clear err=%b dn=%b want 0 1", ERROR, DONE);
        else passed++;
        tick();
    endtask

    task automatic test_abort_in_idle();
        ABORT = 1'b1;
        accept(8'd1);
        checks++;
        if (BUSY !== 1'b1 || TIMER_RESET !== 1'b1 || REQ_READY !== 1'b0 || REPS_LEFT !== 8'd1)
            $display("FAIL idle_abort_accept busy=%b rs=%b rdy=%b reps=%0d want 1 1 0 1",
                     BUSY, TIMER_RESET, REQ_READY, REPS_LEFT);
        else passed++;
        tick();
        ABORT = 1'b0;
        checks++;
        if (TIMER_RESET !== 1'b1 || TIMER_START !== 1'b0 || BUSY !== 1'b1)
            $display("FAIL idle_abort_abrt rs=%b st=%b busy=%b want 1 0 1", TIMER_RESET, TIMER_START, BUSY);
        else passed++;
        tick();
        checks++;
        if (REQ_READY !== 1'b1 || REPS_LEFT !== 8'd0 || DONE !== 1'b0)
            $display("FAIL idle_abort_end rdy=%b reps=%0d dn=%b want 1 0 0", REQ_READY, REPS_LEFT, DONE);
        else passed++;
    endtask

    initial begin
        #2;
        test_reset();
        test_two_runs();
        test_zero_reps();
        test_abort_vs_ready();
        test_watchdog();
        test_abort_in_idle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout passed=%0d checks=%0d", passed, checks);
        $fatal(1);
    end

endmodule
